rv32i_regfile_write_arbiter: RTL
================================

// Module: rv32i_regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port among NUM_REQ writeback sources
//  (e.g. ALU, load unit, CSR/multi-cycle unit) using a valid/ready handshake.
//  Drives the register file's wr_enable/wr_addr/wr_data from a registered stage.
//  Keeps a pending-write scoreboard of reserved destination registers, which
//  decode uses for RAW hazard stalls.
// PARAMETERS
//  NUM_REQ         3   number of writeback requesters (2..8)
//  NUM_OF_SETS     32  register count; AW = $clog2(NUM_OF_SETS)
//  DATA_BUS_WIDTH  32  register data width (DW)
// PORTS
//  clk           in   1                 single clock; all state updates on rising edge
//  rst           in   1                 reset, asynchronous, active-low (asserted when 0)
//  req_valid     in   NUM_REQ           per-requester write request
//  req_addr      in   NUM_REQ*AW        packed destination addresses; requester i at [i*AW +: AW]
//  req_data      in   NUM_REQ*DW        packed write data; requester i at [i*DW +: DW]
//  req_ready     out  NUM_REQ           one-hot grant; handshake completes when valid & ready
//  rf_wr_enable  out  1                 register-file write enable
//  rf_wr_addr    out  AW                register-file write address
//  rf_wr_data    out  DW                register-file write data
//  rsv_valid     in   1                 reserve a destination at instruction issue
//  rsv_addr      in   AW                register being reserved
//  pending       out  NUM_OF_SETS       bit r = 1 while a write to register r is outstanding
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): rf_wr_enable=0, rf_wr_addr=0, rf_wr_data=0,
//    pending=0, round-robin pointer ptr=0. req_ready reads 0 because no request is valid.
//  - Arbitration (combinational):
//    - Grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
//    - req_ready = one-hot grant; all bits are 0 when no request is valid.
//    - At most one handshake per cycle. The port never back-pressures, so a
//      lone requester is granted in the same cycle it asserts valid.
//  - Pointer: on a handshake by requester g, ptr <= (g+1) mod NUM_REQ.
//    With no handshake, ptr holds.
//  - Requester protocol: a requester that is not granted must hold valid,
//    addr and data stable until it is granted. The bench asserts this.
//  - Write stage: 1-cycle latency. On the edge after a handshake by g:
//    - rf_wr_enable <= (addr_g != 0)
//    - rf_wr_addr <= addr_g
//    - rf_wr_data <= data_g
//    With no handshake, rf_wr_enable <= 0 and addr/data hold their last values.
//  - x0 rule: a request with address 0 is still granted and consumed (ready=1),
//    but it never asserts rf_wr_enable and never touches pending.
//  - Scoreboard, per register r != 0:
//    - set when rsv_valid & rsv_addr == r
//    - cleared when a handshake writes r, i.e. in the same cycle the grant
//      occurs, so pending drops together with the registered write
//    - if set and clear hit the same r in the same cycle, set wins
//      (a new reservation overrides the retiring write)
//    - pending[0] is hardwired to 0
//  - A write to a non-pending register is legal: it is performed, and pending stays 0.
//  - Reset mid-operation: all in-flight grants and pending bits are dropped
//    immediately; no write is issued after rst deasserts.
// CONFIGURATION
//  RF_ARB_FIXED_PRIO_EN
//   defined: fixed priority, requester 0 highest and NUM_REQ-1 lowest;
//            ptr is removed and grant = lowest-index valid.
//   undefined (default): round-robin as described in BEHAVIOUR.
// TESTING
//  1. Reset: rst=0 while requests are active -> all outputs 0 at once;
//     after release, rf_wr_enable=0 until a handshake occurs.
//  2. Single requester: req_valid=3'b010, addr=5, data=32'hDEAD_BEEF
//     -> req_ready=3'b010 in the same cycle; next cycle rf_wr_enable=1,
//     rf_wr_addr=5, rf_wr_data=DEADBEEF.
//  3. Round-robin: all three valid continuously with addrs 1,2,3
//     -> grants 0,1,2,0,...; rf_wr_addr sequence 1,2,3 on consecutive cycles.
//     With RF_ARB_FIXED_PRIO_EN, requester 0 is granted every cycle.
//  4. x0 request: req_valid=3'b001, addr=0 -> ready=1, rf_wr_enable stays 0,
//     pending unchanged.
//  5. Scoreboard: rsv addr 7 -> pending[7]=1 next cycle; handshake to addr 7
//     -> pending[7]=0 on the same edge that the rf write is registered;
//     rsv 7 and write 7 in the same cycle -> pending[7] stays 1.
//  6. rsv_valid with rsv_addr=0 -> pending stays 0; a write to non-pending
//     reg 9 -> rf write occurs, pending[9]=0.

Source files
------------

// File: rtl/rv32i_regfile_write_arbiter_if.sv
// Writeback request bundle: NUM_REQ packed requesters sharing one
// register-file write port via valid/ready.
`timescale 1ns/1ps
interface rv32i_regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rv32i_regfile_write_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (default: round-robin).
`timescale 1ns/1ps
module rv32i_regfile_write_arbiter #(
  parameter  int NUM_REQ        = 3,
  parameter  int NUM_OF_SETS    = 32,
  parameter  int DATA_BUS_WIDTH = 32,
  localparam int AW             = $clog2(NUM_OF_SETS),
  localparam int DW             = DATA_BUS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32i_regfile_write_arbiter_if.slave req,
  output logic                   rf_wr_enable,
  output logic [AW-1:0]          rf_wr_addr,
  output logic [DW-1:0]          rf_wr_data,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_addr,
  output logic [NUM_OF_SETS-1:0] pending
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     vld;
  logic [NUM_REQ-1:0]     gnt;
  logic                   hs;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_data;
  logic [NUM_OF_SETS-1:0] set_mask;
  logic [NUM_OF_SETS-1:0] clr_mask;
  logic [NUM_OF_SETS-1:0] pend_q;
  logic [NUM_OF_SETS-1:0] pend_nxt;

  function automatic logic [NUM_REQ-1:0] first_set(
    input logic [NUM_REQ-1:0] v
  );
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Requests are masked while in reset so nothing is granted.
  assign vld = req.req_valid & {NUM_REQ{rst}};

`ifdef RF_ARB_FIXED_PRIO_EN

  always_comb begin
    gnt = first_set(vld);
  end

`else

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] vld_hi;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (PW'(i) >= ptr);
    end
  end

  // Scan from ptr upward first, then wrap to the low requesters.
  assign vld_hi = vld & hi_mask;

  always_comb begin
    if (|vld_hi) begin
      gnt = first_set(vld_hi);
    end else begin
      gnt = first_set(vld);
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = gnt_idx | PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (hs) begin
      if (gnt_idx == PW'(NUM_REQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt_idx + 1'b1;
      end
    end
  end

`endif

  assign hs            = |gnt;
  assign req.req_ready = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req.req_addr[i*AW +: AW];
        sel_data = sel_data | req.req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wr_enable <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
    end else begin
      rf_wr_enable <= hs && (sel_addr != '0);
      if (hs) begin
        rf_wr_addr <= sel_addr;
        rf_wr_data <= sel_data;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsv_valid) begin
      set_mask[rsv_addr] = 1'b1;
    end
    if (hs) begin
      clr_mask[sel_addr] = 1'b1;
    end
  end

  // A same-cycle reservation beats the retiring write; x0 never pends.
  always_comb begin
    pend_nxt    = (pend_q & ~clr_mask) | set_mask;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  assign pending = pend_q;

endmodule
